// File: rtl/mem_arbiter.sv
// Round-robin arbiter and sequencer that shares one fixed-latency memory port
// between the instruction-fetch and data requesters of a multicycle core.
module mem_arbiter #(
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int LAT = 2
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_ack,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_ack,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;
  localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

  state_t        state_q, state_d;
  logic          owner_dm_q, owner_dm_d;
  logic          last_dm_q, last_dm_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d, dm_rdata_q, dm_rdata_d;
  logic          if_ack_q, if_ack_d, dm_ack_q, dm_ack_d, busy_q, busy_d;
  logic          win_dm;

  // On a tie the requester that was not granted last wins.
  assign win_dm = dm_req & (~if_req | ~last_dm_q);

  always_comb begin
    state_d     = state_q;
    owner_dm_d  = owner_dm_q;
    last_dm_d   = last_dm_q;
    cnt_d       = cnt_q;
    mem_en_d    = 1'b0;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_ack_d    = 1'b0;
    dm_ack_d    = 1'b0;
    case (state_q)
      IDLE: begin
        // The memory-side registers double as the latched request, so the
        // strobe and its qualifiers appear together in the ACCESS cycle.
        if (if_req | dm_req) begin
          owner_dm_d = win_dm;
          mem_en_d   = 1'b1;
          mem_we_d   = win_dm & dm_we;
          mem_addr_d = win_dm ? dm_addr : if_addr;
          if (win_dm) mem_wdata_d = dm_wdata;
          state_d    = ACCESS;
        end
      end
      ACCESS: begin
        cnt_d   = CNT_INIT;
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          if (!mem_we_q) begin
            if (owner_dm_q) dm_rdata_d = mem_rdata;
            else            if_rdata_d = mem_rdata;
          end
          dm_ack_d = owner_dm_q;
          if_ack_d = ~owner_dm_q;
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        last_dm_d = owner_dm_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q     <= IDLE;
      owner_dm_q  <= 1'b0;
      last_dm_q   <= 1'b0;
      cnt_q       <= 4'd0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_dm_q  <= owner_dm_d;
      last_dm_q   <= last_dm_d;
      cnt_q       <= cnt_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_ack_q    <= if_ack_d;
      dm_ack_q    <= dm_ack_d;
      busy_q      <= busy_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign if_ack    = if_ack_q;
  assign dm_ack    = dm_ack_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: three instances (LAT 2, 1, 15), each with its own
// fixed-latency memory that drives noise except in the cycle data is due.
module tb_mem_arbiter;
  localparam int N = 3;

  logic clk = 1'b0;
  logic clr = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic        if_req   [N];
  logic [31:0] if_addr  [N];
  logic [31:0] if_rdata [N];
  logic        if_ack   [N];
  logic        dm_req   [N];
  logic        dm_we    [N];
  logic [31:0] dm_addr  [N];
  logic [31:0] dm_wdata [N];
  logic [31:0] dm_rdata [N];
  logic        dm_ack   [N];
  logic        mem_en   [N];
  logic        mem_we   [N];
  logic [31:0] mem_addr [N];
  logic [31:0] mem_wdata[N];
  logic        busy     [N];

  logic [31:0] ref_mem [256];
  logic        o_en[64], o_we[64], o_iack[64], o_dack[64], o_busy[64];
  logic [31:0] o_addr[64], o_wdata[64], o_ird[64], o_drd[64];

  function automatic int lat_of(int g);
    return (g == 0) ? 2 : (g == 1) ? 1 : 15;
  endfunction

  function automatic logic [31:0] init_word(int idx);
    if (idx == 0) return 32'h3C01_0001;
    return 32'(idx) * 32'h9E37_79B9 ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [132:0] outs(int g);
    return {mem_en[g], mem_we[g], mem_addr[g], mem_wdata[g], if_ack[g], dm_ack[g],
            if_rdata[g], dm_rdata[g], busy[g]};
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_env
    localparam int L = (g == 0) ? 2 : (g == 1) ? 1 : 15;
    logic [31:0] rd = '0;
    logic [31:0] dat = '0;
    logic [31:0] wmem [256];
    bit          wr [256];
    int          due = -1;

    always @(negedge clk) begin
      if (mem_en[g] === 1'b1) begin
        if (mem_we[g]) begin
          wmem[mem_addr[g][9:2]] <= mem_wdata[g];
          wr[mem_addr[g][9:2]]   <= 1'b1;
        end else begin
          due <= cyc + L;
          dat <= wr[mem_addr[g][9:2]] ? wmem[mem_addr[g][9:2]] : init_word(int'(mem_addr[g][9:2]));
        end
      end
      rd <= (cyc == due) ? dat : $urandom;
    end

    mem_arbiter #(.AW(32), .DW(32), .LAT(L)) dut (
      .clk(clk), .clr(clr),
      .if_req(if_req[g]), .if_addr(if_addr[g]), .if_rdata(if_rdata[g]), .if_ack(if_ack[g]),
      .dm_req(dm_req[g]), .dm_we(dm_we[g]), .dm_addr(dm_addr[g]), .dm_wdata(dm_wdata[g]),
      .dm_rdata(dm_rdata[g]), .dm_ack(dm_ack[g]),
      .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_addr(mem_addr[g]), .mem_wdata(mem_wdata[g]),
      .mem_rdata(rd), .busy(busy[g])
    );
  end

  task automatic drive(input int g, input bit ir, input logic [31:0] ia, input bit dr,
                       input bit dwe, input logic [31:0] da, input logic [31:0] dd);
    @(posedge clk); #1;
    if_req[g] = ir; if_addr[g] = ia;
    dm_req[g] = dr; dm_we[g] = dwe; dm_addr[g] = da; dm_wdata[g] = dd;
  endtask

  // Records cycles 1..n after a drive; a requester drops req the cycle after its ack.
  task automatic observe(input int g, input int n, input bit drop);
    o_iack[0] = 1'b0; o_dack[0] = 1'b0;
    for (int c = 1; c <= n; c++) begin
      @(posedge clk); #1;
      if (drop && o_iack[c-1] === 1'b1) if_req[g] = 1'b0;
      if (drop && o_dack[c-1] === 1'b1) dm_req[g] = 1'b0;
      @(negedge clk);
      o_en[c] = mem_en[g]; o_we[c] = mem_we[g]; o_addr[c] = mem_addr[g]; o_wdata[c] = mem_wdata[g];
      o_iack[c] = if_ack[g]; o_dack[c] = dm_ack[g]; o_ird[c] = if_rdata[g]; o_drd[c] = dm_rdata[g];
      o_busy[c] = busy[g];
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    clr = 1'b0;
    for (int g = 0; g < N; g++) begin if_req[g] = 1'b0; dm_req[g] = 1'b0; end
    @(posedge clk); #1;
    clr = 1'b1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int g = 0; g < N; g++) begin
      checks++;
      if (outs(g) !== '0) begin errors++; $display("FAIL reset_outputs g=%0d got=%h want=0", g, outs(g)); end
    end
    @(posedge clk); #1;
    clr = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (busy[0] !== 1'b0 || mem_en[0] !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset busy=%b mem_en=%b want 0 0", busy[0], mem_en[0]);
    end
  endtask

  task automatic test_fetch_read();
    int n_en = 0; bit busy_ok = 1'b1; bit early = 1'b0;
    drive(0, 1'b1, 32'h0000_3000, 1'b0, 1'b0, '0, '0);
    observe(0, 4, 1'b1);
    for (int c = 1; c <= 4; c++) begin
      if (o_en[c] === 1'b1) n_en++;
      if (o_busy[c] !== 1'b1) busy_ok = 1'b0;
      if (c < 4 && (o_iack[c] !== 1'b0 || o_dack[c] !== 1'b0)) early = 1'b1;
    end
    checks++;
    if ({o_en[1], o_we[1], o_addr[1]} !== {1'b1, 1'b0, 32'h0000_3000}) begin
      errors++; $display("FAIL fetch_issue got en=%b we=%b addr=%h want 1 0 00003000", o_en[1], o_we[1], o_addr[1]);
    end
    checks++;
    if ({o_iack[4], o_dack[4]} !== 2'b10 || o_ird[4] !== 32'h3C01_0001) begin
      errors++; $display("FAIL fetch_ack got iack=%b dack=%b rdata=%h want 1 0 3c010001", o_iack[4], o_dack[4], o_ird[4]);
    end
    checks++;
    if (n_en != 1 || !busy_ok || early) begin
      errors++; $display("FAIL fetch_shape got en_count=%0d busy_ok=%b early_ack=%b want 1 1 0", n_en, busy_ok, early);
    end
  endtask

  task automatic test_data_write();
    int n_en = 0; bit stray = 1'b0;
    drive(0, 1'b0, '0, 1'b1, 1'b0, 32'h0000_0020, '0);
    observe(0, 4, 1'b1);
    checks++;
    if (o_dack[4] !== 1'b1 || o_drd[4] !== ref_mem[8]) begin
      errors++; $display("FAIL data_read got dack=%b rdata=%h want 1 %h", o_dack[4], o_drd[4], ref_mem[8]);
    end
    drive(0, 1'b0, '0, 1'b1, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
    observe(0, 4, 1'b1);
    ref_mem[4] = 32'hDEAD_BEEF;
    for (int c = 1; c <= 4; c++) begin
      if (o_en[c] === 1'b1) n_en++;
      if (o_iack[c] !== 1'b0 || (c < 4 && o_dack[c] !== 1'b0)) stray = 1'b1;
    end
    checks++;
    if ({o_en[1], o_we[1], o_addr[1], o_wdata[1]} !== {1'b1, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF} || n_en != 1) begin
      errors++; $display("FAIL write_issue got en=%b we=%b addr=%h wdata=%h count=%0d want 1 1 00000010 deadbeef 1",
                         o_en[1], o_we[1], o_addr[1], o_wdata[1], n_en);
    end
    checks++;
    if (o_dack[4] !== 1'b1 || stray || o_drd[4] !== ref_mem[8]) begin
      errors++; $display("FAIL write_ack got dack=%b stray=%b dm_rdata=%h want 1 0 %h", o_dack[4], stray, o_drd[4], ref_mem[8]);
    end
    drive(0, 1'b1, 32'h0000_0010, 1'b0, 1'b0, '0, '0);
    observe(0, 4, 1'b1);
    checks++;
    if (o_iack[4] !== 1'b1 || o_ird[4] !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL write_readback got iack=%b rdata=%h want 1 deadbeef", o_iack[4], o_ird[4]);
    end
  endtask

  task automatic check_tie(input string name);
    int n_i = 0, n_d = 0, n_en = 0; bit both = 1'b0;
    drive(0, 1'b1, 32'h0000_3000, 1'b1, 1'b0, 32'h0000_0020, '0);
    observe(0, 9, 1'b1);
    for (int c = 1; c <= 9; c++) begin
      if (o_iack[c] === 1'b1) n_i++;
      if (o_dack[c] === 1'b1) n_d++;
      if (o_iack[c] === 1'b1 && o_dack[c] === 1'b1) both = 1'b1;
      if (o_en[c] === 1'b1) n_en++;
    end
    checks++;
    if (o_dack[4] !== 1'b1 || o_iack[4] !== 1'b0 || o_drd[4] !== ref_mem[8]) begin
      errors++; $display("FAIL %s_dm_first got dack=%b iack=%b rdata=%h want 1 0 %h", name, o_dack[4], o_iack[4], o_drd[4], ref_mem[8]);
    end
    checks++;
    if (o_en[6] !== 1'b1 || o_addr[6] !== 32'h0000_3000 || o_iack[9] !== 1'b1 || o_ird[9] !== 32'h3C01_0001) begin
      errors++; $display("FAIL %s_if_second got en6=%b addr6=%h iack9=%b rdata=%h want 1 00003000 1 3c010001",
                         name, o_en[6], o_addr[6], o_iack[9], o_ird[9]);
    end
    checks++;
    if (n_i != 1 || n_d != 1 || n_en != 2 || both) begin
      errors++; $display("FAIL %s_counts got iacks=%0d dacks=%0d ens=%0d both=%b want 1 1 2 0", name, n_i, n_d, n_en, both);
    end
  endtask

  task automatic test_tie_after_reset();
    pulse_reset();
    check_tie("tie");
  endtask

  task automatic test_repeated_tie();
    int n_ack = 0, n_en = 0; bit both = 1'b0;
    drive(0, 1'b1, 32'h0000_3000, 1'b1, 1'b0, 32'h0000_0020, '0);
    observe(0, 19, 1'b0);
    @(posedge clk); #1;
    if_req[0] = 1'b0; dm_req[0] = 1'b0;
    for (int j = 0; j < 4; j++) begin
      int c;
      c = 4 + 5 * j;
      checks++;
      if ({o_dack[c], o_iack[c]} !== ((j % 2 == 0) ? 2'b10 : 2'b01) || o_en[c-3] !== 1'b1) begin
        errors++; $display("FAIL rr_grant%0d got dack=%b iack=%b en=%b want_dm=%0d", j, o_dack[c], o_iack[c], o_en[c-3], (j % 2 == 0));
      end
    end
    for (int c = 1; c <= 19; c++) begin
      if (o_iack[c] === 1'b1) n_ack++;
      if (o_dack[c] === 1'b1) n_ack++;
      if (o_iack[c] === 1'b1 && o_dack[c] === 1'b1) both = 1'b1;
      if (o_en[c] === 1'b1) n_en++;
    end
    checks++;
    if (n_ack != 4 || n_en != 4 || both) begin
      errors++; $display("FAIL rr_counts got acks=%0d ens=%0d both=%b want 4 4 0", n_ack, n_en, both);
    end
  endtask

  task automatic test_reset_mid();
    bit stray = 1'b0;
    drive(0, 1'b0, '0, 1'b1, 1'b0, 32'h0000_0020, '0);
    observe(0, 4, 1'b1);
    drive(0, 1'b1, 32'h0000_3000, 1'b0, 1'b0, '0, '0);
    observe(0, 2, 1'b0);
    @(posedge clk); #1;
    clr = 1'b0;
    #1;
    checks++;
    if (outs(0) !== '0) begin errors++; $display("FAIL reset_mid_outputs got=%h want=0", outs(0)); end
    if_req[0] = 1'b0; dm_req[0] = 1'b0;
    @(posedge clk); #1;
    clr = 1'b1;
    observe(0, 4, 1'b0);
    for (int c = 1; c <= 4; c++)
      if (o_iack[c] !== 1'b0 || o_dack[c] !== 1'b0 || o_en[c] !== 1'b0 || o_busy[c] !== 1'b0) stray = 1'b1;
    checks++;
    if (stray) begin errors++; $display("FAIL reset_mid_abort got activity=1 want 0"); end
    check_tie("post_reset");
  endtask

  task automatic test_lat_ext();
    for (int g = 1; g < N; g++) begin
      int L; bit early;
      L = lat_of(g);
      early = 1'b0;
      drive(g, 1'b1, 32'h0000_3000, 1'b0, 1'b0, '0, '0);
      observe(g, L + 2, 1'b1);
      for (int c = 1; c < L + 2; c++)
        if (o_iack[c] !== 1'b0 || o_dack[c] !== 1'b0 || (c > 1 && o_en[c] !== 1'b0)) early = 1'b1;
      checks++;
      if (o_en[1] !== 1'b1 || o_iack[L+2] !== 1'b1 || o_ird[L+2] !== 32'h3C01_0001 || early) begin
        errors++; $display("FAIL lat%0d_fetch got en1=%b ack=%b rdata=%h early=%b want 1 1 3c010001 0",
                           L, o_en[1], o_iack[L+2], o_ird[L+2], early);
      end
      drive(g, 1'b0, '0, 1'b0, 1'b0, '0, '0);
    end
  endtask

  task automatic test_random();
    bit last_dm = 1'b0;
    logic [31:0] exp_i = '0;
    logic [31:0] exp_d = '0;
    int L;
    L = lat_of(0);
    pulse_reset();
    for (int b = 0; b < 24; b++) begin
      int pat, nacc, n, n_en, n_ack, k, c;
      bit ir, dr, dwe, fdm, both;
      bit isdm [2];
      int en_c [2], ack_c [2];
      logic [31:0] ia, da, dd, ea;
      logic [31:0] ei [2], ed [2];
      pat = $urandom_range(3, 1);
      ir = pat[0]; dr = pat[1];
      ia = ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(15, 0) << 2);
      da = ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(15, 0) << 2);
      dwe = 1'($urandom_range(1, 0));
      dd = $urandom;
      drive(0, ir, ia, dr, dwe, da, dd);
      nacc = int'(ir) + int'(dr);
      fdm = dr && (!ir || !last_dm);
      k = 0;
      for (int j = 0; j < nacc; j++) begin
        isdm[j] = (j == 0) ? fdm : !fdm;
        en_c[j] = k + 1;
        ack_c[j] = k + L + 2;
        k = ack_c[j] + 1;
        if (isdm[j]) begin
          if (dwe) ref_mem[da[9:2]] = dd;
          else     exp_d = ref_mem[da[9:2]];
        end else begin
          exp_i = ref_mem[ia[9:2]];
        end
        ei[j] = exp_i; ed[j] = exp_d;
        last_dm = isdm[j];
      end
      n = ack_c[nacc-1];
      observe(0, n, 1'b1);
      for (int j = 0; j < nacc; j++) begin
        c = en_c[j];
        ea = isdm[j] ? da : ia;
        checks++;
        if (o_en[c] !== 1'b1 || o_addr[c] !== ea || o_we[c] !== (isdm[j] & dwe) ||
            ((isdm[j] & dwe) && o_wdata[c] !== dd)) begin
          errors++; $display("FAIL rand_issue b=%0d j=%0d got en=%b addr=%h we=%b wdata=%h want 1 %h %b %h",
                             b, j, o_en[c], o_addr[c], o_we[c], o_wdata[c], ea, isdm[j] & dwe, dd);
        end
        c = ack_c[j];
        checks++;
        if ({o_dack[c], o_iack[c]} !== {isdm[j], !isdm[j]} || o_ird[c] !== ei[j] || o_drd[c] !== ed[j]) begin
          errors++; $display("FAIL rand_ack b=%0d j=%0d got dack=%b iack=%b ird=%h drd=%h want %b %b %h %h",
                             b, j, o_dack[c], o_iack[c], o_ird[c], o_drd[c], isdm[j], !isdm[j], ei[j], ed[j]);
        end
      end
      n_en = 0; n_ack = 0; both = 1'b0;
      for (int cc = 1; cc <= n; cc++) begin
        if (o_en[cc] === 1'b1) n_en++;
        if (o_iack[cc] === 1'b1) n_ack++;
        if (o_dack[cc] === 1'b1) n_ack++;
        if (o_iack[cc] === 1'b1 && o_dack[cc] === 1'b1) both = 1'b1;
      end
      checks++;
      if (n_en != nacc || n_ack != nacc || both) begin
        errors++; $display("FAIL rand_counts b=%0d got ens=%0d acks=%0d both=%b want %0d %0d 0", b, n_en, n_ack, both, nacc, nacc);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog cycle=%0d limit reached", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    for (int g = 0; g < N; g++) begin
      if_req[g] = 1'b0; if_addr[g] = '0; dm_req[g] = 1'b0; dm_we[g] = 1'b0;
      dm_addr[g] = '0; dm_wdata[g] = '0;
    end
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    test_reset();
    test_fetch_read();
    test_data_write();
    test_tie_after_reset();
    test_repeated_tie();
    test_reset_mid();
    test_lat_ext();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
